// File: rtl/controle_pkg.sv
// Shared definitions for the multi-cycle RV32 sequencer.
// Holds the supported opcodes, the FSM state encoding, the ALU / source-B
// select codes, the instruction class enum and an opcode-to-class decoder.
package controle_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_t;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_R    = 3'd1,
        CLS_LW   = 3'd2,
        CLS_SW   = 3'd3,
        CLS_BEQ  = 3'd4
    } class_t;

    // Unsupported opcodes map to CLS_NONE, which DECODE treats as illegal.
    function automatic class_t decode_class(input logic [6:0] op);
        class_t cls;
        case (op)
            OP_R:    cls = CLS_R;
            OP_LW:   cls = CLS_LW;
            OP_SW:   cls = CLS_SW;
            OP_BEQ:  cls = CLS_BEQ;
            default: cls = CLS_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/controle_multiciclo_contador_espera.sv
// contador_espera: memory wait counter with terminal-count detect.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   clear_i     synchronous clear (has priority over enable_i)
//   enable_i    count one waiting cycle
//   expired_o   counter currently holds TIMEOUT-1
module contador_espera #(
    parameter int CNT_W   = 5,
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/controle_multiciclo.sv
// controle_multiciclo: multi-cycle sequencer for an RV32 datapath supporting
// R-type add, lw, sw and beq. Drives datapath strobes and mux selects per state.
// Ports:
//   clk, rst_n      clock / async active-low reset
//   opcode          IR[6:0], valid from DECODE onward
//   mem_ready       memory completion strobe
//   pc_write, pc_write_cond, pc_source, ir_write, i_or_d, mem_read, mem_write,
//   reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op   datapath controls
//   instr_done      retire pulse
//   illegal_instr   unsupported opcode pulse (DECODE)
//   bus_err         memory wait timeout pulse
//   state_dbg_o     current FSM state
// Memory handshake: a request (mem_read/mem_write with i_or_d) is held stable in
// FETCH/MEM until mem_ready=1 completes it in that same cycle; mem_ready is
// ignored in every other state. If TIMEOUT cycles pass without mem_ready the
// request is dropped, bus_err pulses and the instruction restarts at FETCH.
module controle_multiciclo
    import controle_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_source,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       instr_done,
    output logic       illegal_instr,
    output logic       bus_err,
    output logic [2:0] state_dbg_o
);

    state_t state_q, state_d;
    class_t class_q, class_d;
    class_t dec_class;

    logic wait_active;
    logic cnt_expired;
    logic timeout;

    assign dec_class   = decode_class(opcode);
    assign wait_active = (state_q == ST_FETCH) || (state_q == ST_MEM);
    // mem_ready in the expiring cycle completes the access instead of aborting.
    assign timeout     = wait_active && !mem_ready && cnt_expired;

    contador_espera #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_espera (
        .clk       (clk),
        .rst_n     (rst_n),
        // A timeout re-enters FETCH from FETCH, so it must clear explicitly.
        .clear_i   ((state_d != state_q) || timeout),
        .enable_i  (wait_active && !mem_ready),
        .expired_o (cnt_expired)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            class_q <= CLS_NONE;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        class_d = class_q;
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH:  state_d = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                class_d = dec_class;
                state_d = (dec_class == CLS_NONE) ? ST_FETCH : ST_EXEC;
            end
            ST_EXEC: begin
                case (class_q)
                    CLS_R:          state_d = ST_WB;
                    CLS_LW, CLS_SW: state_d = ST_MEM;
                    default:        state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (mem_ready) begin
                    state_d = (class_q == CLS_LW) ? ST_WB : ST_FETCH;
                end else if (timeout) begin
                    state_d = ST_FETCH;
                end
            end
            ST_WB:     state_d = ST_FETCH;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_source     = 1'b0;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALU_OP_ADD;
        instr_done    = 1'b0;
        illegal_instr = 1'b0;
        bus_err       = timeout;
        case (state_q)
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                // PC+4 and IR only commit when the fetch actually completes.
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            ST_DECODE: begin
                alu_src_b     = SRCB_IMM;
                illegal_instr = (dec_class == CLS_NONE);
            end
            ST_EXEC: begin
                alu_src_a = 1'b1;
                case (class_q)
                    CLS_R:  alu_op = ALU_OP_FUNCT;
                    CLS_LW, CLS_SW: alu_src_b = SRCB_IMM;
                    CLS_BEQ: begin
                        alu_op        = ALU_OP_SUB;
                        pc_write_cond = 1'b1;
                        pc_source     = 1'b1;
                        instr_done    = 1'b1;
                    end
                    default: alu_src_a = 1'b1;
                endcase
            end
            ST_MEM: begin
                i_or_d     = 1'b1;
                mem_read   = (class_q == CLS_LW);
                mem_write  = (class_q == CLS_SW);
                instr_done = (class_q == CLS_SW) && mem_ready;
            end
            ST_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = (class_q == CLS_LW);
                instr_done = 1'b1;
            end
            default: bus_err = 1'b0;
        endcase
    end

    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
module tb_controle_multiciclo;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                           S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5;
    localparam logic [6:0] R = 7'b0110011, LW = 7'b0000011, SW = 7'b0100011,
                           BEQ = 7'b1100011, BAD = 7'b0010011;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, pc_source, ir_write, i_or_d, mem_read;
    logic       mem_write, reg_write, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, alu_op;
    logic       instr_done, illegal_instr, bus_err;
    logic [2:0] state_dbg;
    logic [16:0] got_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    controle_multiciclo #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .pc_source     (pc_source),
        .ir_write      (ir_write),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .instr_done    (instr_done),
        .illegal_instr (illegal_instr),
        .bus_err       (bus_err),
        .state_dbg_o   (state_dbg)
    );

    assign got_out = {pc_write, pc_write_cond, pc_source, ir_write, i_or_d, mem_read,
                      mem_write, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                      instr_done, illegal_instr, bus_err};

    // Packs one expected output vector in the same order as got_out.
    function automatic logic [16:0] o(input logic pcw, pcwc, pcs, irw, iord, mr, mw,
                                      rw, m2r, sa, input logic [1:0] sb, op,
                                      input logic done, ill, be);
        return {pcw, pcwc, pcs, irw, iord, mr, mw, rw, m2r, sa, sb, op, done, ill, be};
    endfunction

    //                                  pcw pcwc pcs irw iord mr mw rw m2r sa sb     op    dn il be
    function automatic logic [16:0] e_fetch(input logic rdy);
        return o(rdy,0,0,rdy,0,1,0,0,0,0,2'b01,2'b00,0,0,0);
    endfunction
    function automatic logic [16:0] e_fetch_to(); return o(0,0,0,0,0,1,0,0,0,0,2'b01,2'b00,0,0,1); endfunction
    function automatic logic [16:0] e_dec();      return o(0,0,0,0,0,0,0,0,0,0,2'b10,2'b00,0,0,0); endfunction
    function automatic logic [16:0] e_dec_ill();  return o(0,0,0,0,0,0,0,0,0,0,2'b10,2'b00,0,1,0); endfunction
    function automatic logic [16:0] e_ex_r();     return o(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,0,0,0); endfunction
    function automatic logic [16:0] e_ex_ls();    return o(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,0,0,0); endfunction
    function automatic logic [16:0] e_ex_beq();   return o(0,1,1,0,0,0,0,0,0,1,2'b00,2'b01,1,0,0); endfunction
    function automatic logic [16:0] e_mem_lw();   return o(0,0,0,0,1,1,0,0,0,0,2'b00,2'b00,0,0,0); endfunction
    function automatic logic [16:0] e_mem_lw_to();return o(0,0,0,0,1,1,0,0,0,0,2'b00,2'b00,0,0,1); endfunction
    function automatic logic [16:0] e_mem_sw(input logic rdy);
        return o(0,0,0,0,1,0,1,0,0,0,2'b00,2'b00,rdy,0,0);
    endfunction
    function automatic logic [16:0] e_wb_r();     return o(0,0,0,0,0,0,0,1,0,0,2'b00,2'b00,1,0,0); endfunction
    function automatic logic [16:0] e_wb_lw();    return o(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,1,0,0); endfunction

    typedef struct {
        logic [6:0]  op;
        logic        rdy;
        logic [2:0]  st;
        logic [16:0] out;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [6:0] op, input logic rdy,
                                input logic [2:0] st, input logic [16:0] out);
        vec_t v;
        v.op = op; v.rdy = rdy; v.st = st; v.out = out;
        vecs.push_back(v);
    endfunction

    task automatic check_now(input string tag, input int idx,
                             input logic [2:0] st, input logic [16:0] out);
        checks++;
        if (state_dbg !== st) begin
            errors++;
            $display("FAIL %s[%0d] state: got %0d expected %0d", tag, idx, state_dbg, st);
        end
        checks++;
        if (got_out !== out) begin
            errors++;
            $display("FAIL %s[%0d] outputs: got %b expected %b", tag, idx, got_out, out);
        end
    endtask

    // Called at a negedge: drive inputs, check, move to the next negedge.
    task automatic step(input string tag, input int idx, input logic [6:0] op,
                        input logic rdy, input logic [2:0] st, input logic [16:0] out);
        opcode    = op;
        mem_ready = rdy;
        #1;
        check_now(tag, idx, st, out);
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = 7'd0;
        mem_ready = 1'b1;

        // Zero-wait add, instr_done on cycle 4 after FETCH entry
        add(R,   1, S_IDLE,   17'd0);
        add(R,   1, S_FETCH,  e_fetch(1));
        add(R,   1, S_DECODE, e_dec());
        add(0,   1, S_EXEC,   e_ex_r());
        add(0,   1, S_WB,     e_wb_r());
        // beq: done in EXEC, back in FETCH on cycle 4
        add(BEQ, 1, S_FETCH,  e_fetch(1));
        add(BEQ, 1, S_DECODE, e_dec());
        add(0,   1, S_EXEC,   e_ex_beq());
        // sw with one wait cycle
        add(SW,  1, S_FETCH,  e_fetch(1));
        add(SW,  1, S_DECODE, e_dec());
        add(0,   1, S_EXEC,   e_ex_ls());
        add(0,   0, S_MEM,    e_mem_sw(0));
        add(0,   1, S_MEM,    e_mem_sw(1));
        // lw with three wait cycles: 8 cycles total
        add(LW,  1, S_FETCH,  e_fetch(1));
        add(LW,  1, S_DECODE, e_dec());
        add(0,   1, S_EXEC,   e_ex_ls());
        add(0,   0, S_MEM,    e_mem_lw());
        add(0,   0, S_MEM,    e_mem_lw());
        add(0,   0, S_MEM,    e_mem_lw());
        add(0,   1, S_MEM,    e_mem_lw());
        add(0,   1, S_WB,     e_wb_lw());
        // illegal opcode, then a fetch wait cycle
        add(BAD, 1, S_FETCH,  e_fetch(1));
        add(BAD, 1, S_DECODE, e_dec_ill());
        add(0,   0, S_FETCH,  e_fetch(0));
        add(R,   1, S_FETCH,  e_fetch(1));
        // R with mem_ready toggling outside FETCH/MEM (ignored)
        add(R,   0, S_DECODE, e_dec());
        add(0,   1, S_EXEC,   e_ex_r());
        add(0,   0, S_WB,     e_wb_r());

        repeat (3) @(negedge clk);
        #1;
        check_now("in_reset", 0, S_IDLE, 17'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) step("vec", i, vecs[i].op, vecs[i].rdy, vecs[i].st, vecs[i].out);

        // FETCH timeout: bus_err on the 16th waiting cycle
        for (int i = 1; i <= 15; i++) step("fetch_wait", i, 0, 0, S_FETCH, e_fetch(0));
        step("fetch_timeout", 16, 0, 0, S_FETCH, e_fetch_to());
        // Counter restarts at 0: mem_ready on the 16th cycle wins
        for (int i = 1; i <= 15; i++) step("fetch_wait2", i, 0, 0, S_FETCH, e_fetch(0));
        step("fetch_late_rdy", 16, 0, 1, S_FETCH, e_fetch(1));
        // lw with MEM timeout, instruction is not retired
        step("lw_to", 0, LW, 1, S_DECODE, e_dec());
        step("lw_to", 1, 0, 1, S_EXEC, e_ex_ls());
        for (int i = 1; i <= 15; i++) step("mem_wait", i, 0, 0, S_MEM, e_mem_lw());
        step("mem_timeout", 16, 0, 0, S_MEM, e_mem_lw_to());
        step("after_mem_to", 0, R, 1, S_FETCH, e_fetch(1));
        step("rst_seq", 0, R, 1, S_DECODE, e_dec());

        // Async reset mid-EXEC
        opcode = 0;
        #1;
        check_now("pre_rst_exec", 0, S_EXEC, e_ex_r());
        #1 rst_n = 1'b0;
        #1;
        check_now("async_rst", 0, S_IDLE, 17'd0);
        @(negedge clk);
        #1;
        check_now("rst_held", 0, S_IDLE, 17'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 0, R, 1, S_IDLE, 17'd0);
        step("post_rst", 1, R, 0, S_FETCH, e_fetch(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
